ex_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO registers for the EX stage.

---
 rtl/ex_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the EX stage.
// One bit per cycle for WIDTH cycles; stalls the front end while running and honours flushes.
module ex_muldiv_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_op;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div0_flag;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               op_muldiv;
    logic               op_is_div;
    logic               op_signed;
    logic               accept;
    logic               last_iter;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   commit_hi;
    logic [WIDTH-1:0]   commit_lo;

    assign op_muldiv = ~op[2];
    assign op_is_div = ~op[2] & op[1];
    assign op_signed = ~op[2] & ~op[0];
    assign accept    = start & ~annul & (state != ST_RUN);
    assign last_iter = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));

    // Signed ops work on magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
    assign sign_a = op_signed & opa[WIDTH-1];
    assign sign_b = op_signed & opb[WIDTH-1];
    assign abs_a  = sign_a ? -opa : opa;
    assign abs_b  = sign_b ? -opb : opb;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_op : {WIDTH{1'b0}})};
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, mag_op};
        if (is_div) begin
            if (div_diff[WIDTH])
                acc_step = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_lo ? -acc_step : acc_step;
        quo      = acc_step[WIDTH-1:0];
        rem      = acc_step[2*WIDTH-1:WIDTH];
        if (is_div) begin
            commit_hi = neg_hi ? -rem : rem;
            commit_lo = neg_lo ? -quo : quo;
        end else begin
            commit_hi = prod_fix[2*WIDTH-1:WIDTH];
            commit_lo = prod_fix[WIDTH-1:0];
        end
    end

    // DONE always lasts one cycle, so done is simply the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mag_op    <= '0;
            acc       <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div0_flag <= 1'b0;
            hi_r      <= HILO_RST;
            lo_r      <= HILO_RST;
        end else if (state == ST_RUN) begin
            if (annul) begin
                state <= ST_IDLE;
            end else begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    hi_r      <= commit_hi;
                    lo_r      <= commit_lo;
                    div0_flag <= 1'b0;
                    state     <= ST_DONE;
                end
            end
        end else begin
            state     <= ST_IDLE;
            div0_flag <= 1'b0;
            if (accept) begin
                if (op == OP_MTHI)
                    hi_r <= opa;
                if (op == OP_MTLO)
                    lo_r <= opa;
                if (op_muldiv) begin
                    cnt    <= '0;
                    is_div <= op_is_div;
                    neg_lo <= sign_a ^ sign_b;
                    neg_hi <= sign_a;
                    if (op_is_div) begin
                        mag_op <= abs_b;
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        if (opb == '0) begin
                            div0_flag <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        mag_op <= abs_a;
                        acc    <= {{WIDTH{1'b0}}, abs_b};
                        state  <= ST_RUN;
                    end
                end
            end
        end
    end

    assign stall_req = (accept & op_muldiv) | (state == ST_RUN);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign div0      = (state == ST_DONE) & div0_flag;
    assign hi_o      = hi_r;
    assign lo_o      = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_ex_muldiv_unit;

    localparam int          WIDTH = 32;
    localparam logic [31:0] HRST  = 32'h0000_00C3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    int   done_cyc;
    int   stall_cnt;
    logic saw_div0;
    logic busy_after;

    ex_muldiv_unit #(
        .WIDTH    (WIDTH),
        .HILO_RST (HRST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .annul     (annul),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic s, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b, input logic an);
        rst   = r;
        start = s;
        op    = o;
        opa   = a;
        opb   = b;
        annul = an;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op in cycle 0 and follows it until done or 60 cycles; inj_kind injects an
    // event in cycle inj_cyc: 1 = annul, 2 = MTHI 0x1234 start, 3 = reset.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int inj_kind,
                          output int dcyc, output int scnt, output logic sdiv0, output logic bafter);
        applyStimulus(1'b0, 1'b1, o, a, b, 1'b0);
        #1;
        scnt   = stall_req ? 1 : 0;
        dcyc   = -1;
        sdiv0  = 1'b0;
        bafter = 1'b0;
        for (int k = 1; k <= 60 && dcyc < 0; k++) begin
            @(negedge clk);
            if (k == inj_cyc && inj_kind == 1)
                applyStimulus(1'b0, 1'b0, o, a, b, 1'b1);
            else if (k == inj_cyc && inj_kind == 2)
                applyStimulus(1'b0, 1'b1, 3'b100, 32'h1234, b, 1'b0);
            else if (k == inj_cyc && inj_kind == 3)
                applyStimulus(1'b1, 1'b0, o, a, b, 1'b0);
            else
                applyStimulus(1'b0, 1'b0, o, a, b, 1'b0);
            #1;
            if (stall_req) scnt++;
            if (k == inj_cyc + 1) bafter = busy;
            if (done) begin
                dcyc  = k;
                sdiv0 = div0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        #1;
        checkOutput("reset_busy",  busy,      1'b0);
        checkOutput("reset_done",  done,      1'b0);
        checkOutput("reset_div0",  div0,      1'b0);
        checkOutput("reset_stall", stall_req, 1'b0);
        checkOutput("reset_hi",    hi_o,      HRST);
        checkOutput("reset_lo",    lo_o,      HRST);

        // MTLO in IDLE writes LO on the next edge without stalling
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, OP_MTLO, 32'h55, 32'h0, 1'b0);
        #1;
        checkOutput("mtlo_stall", stall_req, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        #1;
        checkOutput("mtlo_lo",   lo_o, 32'h55);
        checkOutput("mtlo_hi",   hi_o, HRST);
        checkOutput("mtlo_done", done, 1'b0);
        checkOutput("mtlo_busy", busy, 1'b0);

        // MULT -3 * 5
        @(negedge clk);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h5, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("mult_done_cycle", done_cyc,  33);
        checkOutput("mult_stall_cnt",  stall_cnt, 33);
        checkOutput("mult_div0",       saw_div0,  1'b0);
        checkOutput("mult_hi",         hi_o,      32'hFFFF_FFFF);
        checkOutput("mult_lo",         lo_o,      32'hFFFF_FFF1);

        // Back-to-back issues from DONE
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("multu_done_cycle", done_cyc, 33);
        checkOutput("multu_hi",         hi_o,     32'hFFFF_FFFE);
        checkOutput("multu_lo",         lo_o,     32'h0000_0001);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("mult_m1_hi", hi_o, 32'h0);
        checkOutput("mult_m1_lo", lo_o, 32'h1);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("div_done_cycle", done_cyc, 33);
        checkOutput("div_lo",         lo_o,     32'hFFFF_FFFD);
        checkOutput("div_hi",         hi_o,     32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'h7, 32'h2, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("divu_lo", lo_o, 32'h3);
        checkOutput("divu_hi", hi_o, 32'h1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("div_min_lo",   lo_o,     32'h8000_0000);
        checkOutput("div_min_hi",   hi_o,     32'h0);
        checkOutput("div_min_div0", saw_div0, 1'b0);

        // Divide by zero finishes in cycle 1
        run_op(OP_DIV, 32'h5, 32'h0, 0, 0, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("div0_done_cycle", done_cyc,  1);
        checkOutput("div0_flag",       saw_div0,  1'b1);
        checkOutput("div0_stall_cnt",  stall_cnt, 1);
        checkOutput("div0_hi",         hi_o,      32'h0);
        checkOutput("div0_lo",         lo_o,      32'h8000_0000);

        // Annul in cycle 10 of DIVU 100/3
        run_op(OP_DIVU, 32'd100, 32'd3, 10, 1, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("annul_no_done",   done_cyc,   -1);
        checkOutput("annul_busy_c11",  busy_after, 1'b0);
        checkOutput("annul_stall_cnt", stall_cnt,  11);
        checkOutput("annul_hi",        hi_o,       32'h0);
        checkOutput("annul_lo",        lo_o,       32'h8000_0000);

        // start together with annul is ignored
        applyStimulus(1'b0, 1'b1, OP_MULT, 32'h2, 32'h3, 1'b1);
        #1;
        checkOutput("start_annul_stall", stall_req, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        #1;
        checkOutput("start_annul_busy", busy, 1'b0);

        // MTHI issued while RUN must not touch HI
        @(negedge clk);
        run_op(OP_MULT, 32'h2, 32'h3, 5, 2, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("mthi_run_done_cycle", done_cyc,  33);
        checkOutput("mthi_run_stall_cnt",  stall_cnt, 33);
        checkOutput("mthi_run_hi",         hi_o,      32'h0);
        checkOutput("mthi_run_lo",         lo_o,      32'h6);

        // Reset in cycle 5 of a MULT
        run_op(OP_MULT, 32'h7, 32'h9, 5, 3, done_cyc, stall_cnt, saw_div0, busy_after);
        checkOutput("rst_run_no_done",   done_cyc,   -1);
        checkOutput("rst_run_busy_c6",   busy_after, 1'b0);
        checkOutput("rst_run_stall_cnt", stall_cnt,  6);
        checkOutput("rst_run_hi",        hi_o,       HRST);
        checkOutput("rst_run_lo",        lo_o,       HRST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
